// File: rtl/credit_fifo_rx.sv
// credit_fifo_rx
// Receiver end of a credit-based, single-clock stream link. The sender pushes
// beats without backpressure, spending one credit per beat. Beats are buffered
// in a 2**LOG_DEPTH entry FIFO and handed to the consumer over valid/ready.
// Popped entries become pending credits, which are returned to the sender in
// coalesced credit beats. After reset the full depth is granted as one beat.
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   in_valid_i      beat from sender (always accepted)
//   in_data_i       beat payload
//   out_valid_o     FIFO not empty
//   out_data_o      head entry
//   out_ready_i     consumer accepts head
//   credit_valid_o  credit beat offered to sender
//   credit_cnt_o    credits carried by the current credit beat
//   credit_ready_i  sender accepts credit beat
//   fill_o          current occupancy
//   overflow_o      sticky: a beat arrived while the FIFO was full
module credit_fifo_rx #(
   parameter int unsigned WIDTH        = 1,
   parameter type         T            = logic [WIDTH-1:0],
   parameter int unsigned LOG_DEPTH    = 3,
   parameter int unsigned CREDIT_BATCH = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   input  T                   in_data_i,
   output logic               out_valid_o,
   output T                   out_data_o,
   input  logic               out_ready_i,
   output logic               credit_valid_o,
   output logic [LOG_DEPTH:0] credit_cnt_o,
   input  logic               credit_ready_i,
   output logic [LOG_DEPTH:0] fill_o,
   output logic               overflow_o
);

   localparam int unsigned DEPTH = 2 ** LOG_DEPTH;

   typedef logic [LOG_DEPTH:0] ptr_t;

   localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
   localparam ptr_t BATCH_P = ptr_t'(CREDIT_BATCH);
   localparam ptr_t ONE_P   = ptr_t'(1);

   typedef enum logic {INIT, RUN} state_t;

   T       mem [DEPTH];
   ptr_t   rptr;
   ptr_t   wptr;
   ptr_t   pending;
   ptr_t   credit_cnt;
   logic   credit_valid;
   logic   overflow;
   state_t state;

   logic   empty;
   logic   full;
   logic   push;
   logic   drop;
   logic   pop;
   ptr_t   pop_inc;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (rptr == wptr);
   assign full    = (rptr[LOG_DEPTH] != wptr[LOG_DEPTH]) &&
                    (rptr[LOG_DEPTH-1:0] == wptr[LOG_DEPTH-1:0]);
   assign push    = in_valid_i && !full;
   assign drop    = in_valid_i && full;
   assign pop     = !empty && out_ready_i;
   assign pop_inc = pop ? ONE_P : '0;

   // Storage: data only, never reset.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push) begin
         mem[wptr[LOG_DEPTH-1:0]] <= in_data_i;
      end
   end

   // Pointers, overflow flag and credit return state machine.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr         <= '0;
         wptr         <= '0;
         pending      <= '0;
         overflow     <= 1'b0;
         state        <= INIT;
         credit_valid <= 1'b1;
         credit_cnt   <= DEPTH_P;
      end else begin
         if (push) wptr <= wptr + ONE_P;
         if (pop)  rptr <= rptr + ONE_P;
         if (drop) overflow <= 1'b1;

         case (state)
            INIT: begin
               pending <= pending + pop_inc;
               if (credit_ready_i) begin
                  credit_valid <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (credit_valid) begin
                  // Offered beat holds stable; pops keep accumulating.
                  pending <= pending + pop_inc;
                  if (credit_ready_i) credit_valid <= 1'b0;
               end else if ((pending >= BATCH_P) || ((pending != '0) && empty)) begin
                  // Snapshot pending into the beat; this cycle's pop starts the next batch.
                  credit_cnt   <= pending;
                  credit_valid <= 1'b1;
                  pending      <= pop_inc;
               end else begin
                  pending <= pending + pop_inc;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   // Outputs are forced to zero while reset is held.
   assign out_valid_o    = rst_ni && !empty;
   assign out_data_o     = rst_ni ? mem[rptr[LOG_DEPTH-1:0]] : T'('0);
   assign fill_o         = rst_ni ? (wptr - rptr) : '0;
   assign credit_valid_o = rst_ni && credit_valid;
   assign credit_cnt_o   = rst_ni ? credit_cnt : '0;
   assign overflow_o     = rst_ni && overflow;

endmodule

// File: tb/tb_credit_fifo_rx.sv
// Bench for credit_fifo_rx with WIDTH=8, LOG_DEPTH=3, CREDIT_BATCH=2.
module tb_credit_fifo_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_v;
   logic [7:0] in_d;
   logic       o_v;
   logic [7:0] o_d;
   logic       o_rdy;
   logic       c_v;
   logic [3:0] c_cnt;
   logic       c_rdy;
   logic [3:0] fill;
   logic       ovf;

   always #5 clk = ~clk;

   credit_fifo_rx #(
      .WIDTH(8),
      .LOG_DEPTH(3),
      .CREDIT_BATCH(2)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .in_valid_i(in_v),
      .in_data_i(in_d),
      .out_valid_o(o_v),
      .out_data_o(o_d),
      .out_ready_i(o_rdy),
      .credit_valid_o(c_v),
      .credit_cnt_o(c_cnt),
      .credit_ready_i(c_rdy),
      .fill_o(fill),
      .overflow_o(ovf)
   );

   // Expected values are those seen during the cycle, before its clock edge.
   // A negative expectation means "don't care".
   typedef struct {
      bit   rst_n;
      bit   in_v;
      int   d;
      bit   o_rdy;
      bit   c_rdy;
      bit   drop;
      int   e_ov;
      int   e_fill;
      int   e_cv;
      int   e_cnt;
      int   e_ovf;
      int   e_data;
   } vec_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb[$];
   vec_t       tbl[19];

   function automatic vec_t mk(bit r, bit iv, int d, bit ordy, bit crdy, bit drp,
                               int ov, int fl, int cv, int cnt, int of, int dat);
      vec_t v;
      v.rst_n = r;   v.in_v = iv;   v.d = d;       v.o_rdy = ordy;
      v.c_rdy = crdy; v.drop = drp; v.e_ov = ov;   v.e_fill = fl;
      v.e_cv = cv;   v.e_cnt = cnt; v.e_ovf = of;  v.e_data = dat;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      if (exp >= 0) begin
         n_tests++;
         if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
         end
      end
   endtask

   task automatic cyc(vec_t v, string tag);
      logic [7:0] exp_d;
      rst_n = v.rst_n;
      in_v  = v.in_v;
      in_d  = v.d[7:0];
      o_rdy = v.o_rdy;
      c_rdy = v.c_rdy;
      if (v.rst_n && v.in_v && !v.drop) sb.push_back(v.d[7:0]);
      @(negedge clk);
      chk({tag, ".out_valid"}, int'(o_v), v.e_ov);
      chk({tag, ".fill"}, int'(fill), v.e_fill);
      chk({tag, ".credit_valid"}, int'(c_v), v.e_cv);
      chk({tag, ".credit_cnt"}, int'(c_cnt), v.e_cnt);
      chk({tag, ".overflow"}, int'(ovf), v.e_ovf);
      chk({tag, ".out_data"}, int'(o_d), v.e_data);
      if (o_v && o_rdy) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.pop: got data 0x%0h, expected no pop (scoreboard empty)", tag, o_d);
         end else begin
            exp_d = sb.pop_front();
            chk({tag, ".pop_data"}, int'(o_d), int'(exp_d));
         end
      end
      @(posedge clk);
      #1;
      if (!v.rst_n) sb.delete();
   endtask

   initial begin
      //           rst in data ordy crdy drp  ov fill cv cnt ovf data
      tbl[0]  = mk(0, 0, 0,    0, 0, 0,   0, 0,   0, 0,  0, 0);
      tbl[1]  = mk(0, 0, 0,    0, 0, 0,   0, 0,   0, 0,  0, 0);
      tbl[2]  = mk(1, 0, 0,    0, 0, 0,   0, 0,   1, 8,  0, -1);
      tbl[3]  = mk(1, 0, 0,    0, 0, 0,   0, 0,   1, 8,  0, -1);
      tbl[4]  = mk(1, 0, 0,    0, 0, 0,   0, 0,   1, 8,  0, -1);
      tbl[5]  = mk(1, 0, 0,    0, 0, 0,   0, 0,   1, 8,  0, -1);
      tbl[6]  = mk(1, 0, 0,    0, 0, 0,   0, 0,   1, 8,  0, -1);
      tbl[7]  = mk(1, 0, 0,    0, 1, 0,   0, 0,   1, 8,  0, -1);
      tbl[8]  = mk(1, 1, 'h11, 0, 0, 0,   0, 0,   0, -1, 0, -1);
      tbl[9]  = mk(1, 1, 'h22, 0, 0, 0,   1, 1,   0, -1, 0, 'h11);
      tbl[10] = mk(1, 1, 'h33, 0, 0, 0,   1, 2,   0, -1, 0, 'h11);
      tbl[11] = mk(1, 0, 0,    0, 0, 0,   1, 3,   0, -1, 0, 'h11);
      tbl[12] = mk(1, 0, 0,    1, 1, 0,   1, 3,   0, -1, 0, -1);
      tbl[13] = mk(1, 0, 0,    1, 1, 0,   1, 2,   0, -1, 0, -1);
      tbl[14] = mk(1, 0, 0,    1, 1, 0,   1, 1,   0, -1, 0, -1);
      tbl[15] = mk(1, 0, 0,    0, 1, 0,   0, 0,   1, 2,  0, -1);
      tbl[16] = mk(1, 0, 0,    0, 1, 0,   0, 0,   0, -1, 0, -1);
      tbl[17] = mk(1, 0, 0,    0, 1, 0,   0, 0,   1, 1,  0, -1);
      tbl[18] = mk(1, 0, 0,    0, 0, 0,   0, 0,   0, -1, 0, -1);

      rst_n = 1'b0; in_v = 1'b0; in_d = '0; o_rdy = 1'b0; c_rdy = 1'b0;
      @(posedge clk);
      #1;

      // Reset, INIT grant, first pushes, pops with batch and flush credits.
      for (int i = 0; i < 19; i++) cyc(tbl[i], $sformatf("row%0d", i));

      // Fill all entries, then push into a full FIFO.
      for (int i = 0; i < 8; i++)
         cyc(mk(1, 1, 'h40 + i, 0, 0, 0, (i > 0) ? 1 : 0, i, 0, -1, 0, -1), $sformatf("fill%0d", i));
      cyc(mk(1, 1, 'hAA, 0, 0, 1,  1, 8, 0, -1, 0, 'h40), "ovf_push");
      cyc(mk(1, 0, 0,    0, 0, 0,  1, 8, 0, -1, 1, 'h40), "ovf_set");

      // Pop five with credit_ready low: beat cnt=2 issues and holds while pending reaches 3.
      for (int k = 0; k < 5; k++)
         cyc(mk(1, 0, 0, 1, 0, 0, 1, 8 - k, (k >= 3) ? 1 : 0, (k >= 3) ? 2 : -1, 1, -1),
             $sformatf("hold_pop%0d", k));
      cyc(mk(1, 0, 0, 0, 0, 0,  1, 3, 1, 2, 1, 'h45), "hold_a");
      cyc(mk(1, 0, 0, 0, 0, 0,  1, 3, 1, 2, 1, 'h45), "hold_b");
      cyc(mk(1, 0, 0, 0, 1, 0,  1, 3, 1, 2, 1, -1),   "accept2");
      cyc(mk(1, 0, 0, 0, 0, 0,  1, 3, 0, -1, 1, -1),  "gap");
      cyc(mk(1, 0, 0, 0, 0, 0,  1, 3, 1, 3, 1, -1),   "beat3");

      // Raise occupancy to 5 with a credit beat outstanding, then reset.
      cyc(mk(1, 1, 'h51, 0, 0, 0,  1, 3, 1, 3, 1, -1),   "push51");
      cyc(mk(1, 1, 'h52, 0, 0, 0,  1, 4, 1, 3, 1, -1),   "push52");
      cyc(mk(1, 0, 0,    0, 0, 0,  1, 5, 1, 3, 1, 'h45), "pre_rst");
      cyc(mk(0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 0, 0),    "in_rst");
      cyc(mk(1, 0, 0,    0, 0, 0,  0, 0, 1, 8, 0, -1),   "regrant");
      cyc(mk(1, 0, 0,    0, 1, 0,  0, 0, 1, 8, 0, -1),   "regrant_acc");

      // One beat through after reset, returned by an idle flush.
      cyc(mk(1, 1, 'h77, 0, 0, 0,  0, 0, 0, -1, 0, -1),  "push77");
      cyc(mk(1, 0, 0,    0, 0, 0,  1, 1, 0, -1, 0, 'h77), "head77");
      cyc(mk(1, 0, 0,    1, 0, 0,  1, 1, 0, -1, 0, -1),  "pop77");
      cyc(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, -1, 0, -1),  "flush_gap");
      cyc(mk(1, 0, 0,    0, 1, 0,  0, 0, 1, 1, 0, -1),   "flush1");
      cyc(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, -1, 0, -1),  "idle_end");

      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
